// File: rtl/segment_counter_if.sv
// Active-low 7-segment bundle {G,F,E,D,C,B,A} for one digit.
// The display driver is the master and whatever watches the digit is the slave.
interface segment_counter_if;
   wire [6:0] seg;

   modport master (output seg);
   modport slave  (input  seg);
endinterface

// File: rtl/segment_counter.sv
// Free-running 0-9 decimal counter on one active-low 7-segment digit.
// The digit steps every HALF_SECOND clocks, and the segment decode is registered.
module segment_counter #(
   parameter int HALF_SECOND = 12_500_000
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   output logic o_Segment1_A,
   output logic o_Segment1_B,
   output logic o_Segment1_C,
   output logic o_Segment1_D,
   output logic o_Segment1_E,
   output logic o_Segment1_F,
   output logic o_Segment1_G
);

   localparam int              CNT_W = $clog2(HALF_SECOND);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_SECOND - 1);
   localparam logic [6:0]      SEG_0 = 7'b1000000;

   // NOTE: declaration initialisers give the power-up state when i_Rst_L is tied high.
   logic [CNT_W-1:0] r_Count = '0;
   logic [3:0]       r_Digit = 4'd0;
   logic [6:0]       r_Seg   = SEG_0;

   logic             w_Last;
   logic [3:0]       w_Digit_Next;
   logic [6:0]       w_Seg_Next;

   assign w_Last = (r_Count == LAST);

   // NOTE: assign a default first so that no path through always_comb leaves a latch.
   always_comb begin
      w_Digit_Next = r_Digit;
      if (w_Last) begin
         w_Digit_Next = (r_Digit == 4'd9) ? 4'd0 : r_Digit + 4'd1;
      end
   end

   always_comb begin
      w_Seg_Next = 7'b1111111;
      unique case (r_Digit)
         4'd0:    w_Seg_Next = 7'b1000000;
         4'd1:    w_Seg_Next = 7'b1111001;
         4'd2:    w_Seg_Next = 7'b0100100;
         4'd3:    w_Seg_Next = 7'b0110000;
         4'd4:    w_Seg_Next = 7'b0011001;
         4'd5:    w_Seg_Next = 7'b0010010;
         4'd6:    w_Seg_Next = 7'b0000010;
         4'd7:    w_Seg_Next = 7'b1111000;
         4'd8:    w_Seg_Next = 7'b0000000;
         4'd9:    w_Seg_Next = 7'b0010000;
         default: w_Seg_Next = 7'b1111111;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments, so all registers sample pre-edge values.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_Count <= '0;
         r_Digit <= 4'd0;
         r_Seg   <= SEG_0;
      end else begin
         r_Count <= w_Last ? '0 : r_Count + 1'b1;
         r_Digit <= w_Digit_Next;
         r_Seg   <= w_Seg_Next;
      end
   end

   assign o_Segment1_A = r_Seg[0];
   assign o_Segment1_B = r_Seg[1];
   assign o_Segment1_C = r_Seg[2];
   assign o_Segment1_D = r_Seg[3];
   assign o_Segment1_E = r_Seg[4];
   assign o_Segment1_F = r_Seg[5];
   assign o_Segment1_G = r_Seg[6];

endmodule

// File: tb/tb_segment_counter.sv
// Directed bench for segment_counter: a reset/sequence/wrap/async-reset instance,
// a tied-high instance, and a HALF_SECOND=2 instance.
module tb_segment_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n_main  = 1'b0;
   logic rst_n_small = 1'b0;
   logic rst_n_tie   = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;
   bit tie_done = 1'b0;
   bit small_done = 1'b0;

   logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   segment_counter_if main_if ();
   segment_counter_if tie_if ();
   segment_counter_if small_if ();

   segment_counter #(.HALF_SECOND(50)) u_main (
      .i_Clk(clk), .i_Rst_L(rst_n_main),
      .o_Segment1_A(main_if.seg[0]), .o_Segment1_B(main_if.seg[1]), .o_Segment1_C(main_if.seg[2]),
      .o_Segment1_D(main_if.seg[3]), .o_Segment1_E(main_if.seg[4]), .o_Segment1_F(main_if.seg[5]),
      .o_Segment1_G(main_if.seg[6])
   );

   segment_counter #(.HALF_SECOND(50)) u_tie (
      .i_Clk(clk), .i_Rst_L(rst_n_tie),
      .o_Segment1_A(tie_if.seg[0]), .o_Segment1_B(tie_if.seg[1]), .o_Segment1_C(tie_if.seg[2]),
      .o_Segment1_D(tie_if.seg[3]), .o_Segment1_E(tie_if.seg[4]), .o_Segment1_F(tie_if.seg[5]),
      .o_Segment1_G(tie_if.seg[6])
   );

   segment_counter #(.HALF_SECOND(2)) u_small (
      .i_Clk(clk), .i_Rst_L(rst_n_small),
      .o_Segment1_A(small_if.seg[0]), .o_Segment1_B(small_if.seg[1]), .o_Segment1_C(small_if.seg[2]),
      .o_Segment1_D(small_if.seg[3]), .o_Segment1_E(small_if.seg[4]), .o_Segment1_F(small_if.seg[5]),
      .o_Segment1_G(small_if.seg[6])
   );

   function automatic logic [6:0] get_seg(input int which);
      case (which)
         0:       return main_if.seg;
         1:       return tie_if.seg;
         default: return small_if.seg;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", tag, got, exp);
      end
   endtask

   // Counts rising edges until the digit changes, then checks pattern and interval.
   task automatic step(input int which, input string tag, input logic [6:0] exp_pat, input int exp_cyc);
      logic [6:0] prev;
      int         n;
      prev = get_seg(which);
      n    = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (get_seg(which) === prev && n < 200);
      check({tag, "_pat"}, 32'(get_seg(which)), 32'(exp_pat));
      check({tag, "_cyc"}, 32'(n), 32'(exp_cyc));
   endtask

   // Reset, full sequence, wrap and asynchronous mid-count reset at HALF_SECOND=50.
   initial begin
      repeat (5) begin
         @(posedge clk);
         #1;
         check("rst_hold", 32'(main_if.seg), 32'(pat[0]));
      end
      @(negedge clk);
      rst_n_main = 1'b1;
      step(0, "d1", pat[1], 51);
      for (int d = 2; d <= 9; d++) step(0, $sformatf("d%0d", d), pat[d], 50);
      step(0, "wrap0", pat[0], 50);
      step(0, "wrap1", pat[1], 50);
      step(0, "wrap2", pat[2], 50);
      for (int d = 3; d <= 5; d++) step(0, $sformatf("r%0d", d), pat[d], 50);
      // Counter has restarted one edge before the 5 appeared; 19 more edges reach count 20.
      repeat (19) @(posedge clk);
      #3;
      check("pre_async", 32'(main_if.seg), 32'(pat[5]));
      rst_n_main = 1'b0;
      #1;
      check("async_rst", 32'(main_if.seg), 32'(pat[0]));
      repeat (2) @(negedge clk);
      check("async_hold", 32'(main_if.seg), 32'(pat[0]));
      rst_n_main = 1'b1;
      step(0, "post_rst1", pat[1], 51);

      for (int i = 0; i < 500 && !(tie_done && small_done); i++) @(posedge clk);
      check("side_done", 32'({tie_done, small_done}), 32'(2'b11));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Reset tied high from time 0: power-up state is digit 0, never unknown.
   initial begin
      #1;
      check("tie_init", 32'(tie_if.seg), 32'(pat[0]));
      for (int c = 1; c <= 120; c++) begin
         @(posedge clk);
         #1;
         check("tie_known", 32'($isunknown(tie_if.seg)), 32'(0));
         if (c == 50) check("tie_c50", 32'(tie_if.seg), 32'(pat[0]));
         if (c == 51) check("tie_c51", 32'(tie_if.seg), 32'(pat[1]));
      end
      tie_done = 1'b1;
   end

   // HALF_SECOND=2: one digit step every two edges, full lap in 20 cycles.
   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("small_rst", 32'(small_if.seg), 32'(pat[0]));
      @(negedge clk);
      rst_n_small = 1'b1;
      step(2, "s1", pat[1], 3);
      for (int d = 2; d <= 9; d++) step(2, $sformatf("s%0d", d), pat[d], 2);
      step(2, "s_wrap", pat[0], 2);
      small_done = 1'b1;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
